// File: rtl/reg_alu_pipe.sv
// reg_alu_pipe: two-stage pipelined register file + ALU.
//   Stage R: combinational operand read (x0 reads as zero), op2 mux, issue
//            handshake; accepted fields/operands latch into stage-E registers.
//   Stage E: ALU execute, register write-back, registered result/eq/out_valid.
// Optional feature macro: FORWARD_EN
//   defined   -> stage-E ALU output is bypassed to stage-R operands, in_ready = !stall
//   undefined -> no bypass; a read-after-write hazard against stage E drops
//                in_ready for one cycle instead (results are identical).
module reg_alu_pipe #(
  parameter int WIDTH   = 32,
  parameter int ADDRESS = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDRESS-1:0] rs1,
  input  logic [ADDRESS-1:0] rs2,
  input  logic [ADDRESS-1:0] rd,
  input  logic               reg_write,
  input  logic               alu_src,
  input  logic [2:0]         alu_ctrl,
  input  logic [WIDTH-1:0]   imm,
  input  logic               stall,
  input  logic               flush,
  output logic               out_valid,
  output logic [WIDTH-1:0]   result,
  output logic               eq,
  output logic [WIDTH-1:0]   a0
);

  localparam int NREG = 2 ** ADDRESS;
  localparam int SHW  = $clog2(WIDTH);

  // ALU operation encodings
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  // Handshake: an instruction transfers on a rising edge where
  // in_valid && in_ready. in_ready is combinational and is low while stall
  // is high (and, without bypass, while a hazard against stage E exists);
  // the issuer must hold its fields stable until the transfer edge.

  // Register file and stage-E state
  logic [WIDTH-1:0]   regs_q [NREG];

  logic               e_valid_q, e_valid_d;
  logic [ADDRESS-1:0] e_rd_q,    e_rd_d;
  logic               e_we_q,    e_we_d;
  logic [2:0]         e_ctrl_q,  e_ctrl_d;
  logic [WIDTH-1:0]   e_op1_q,   e_op1_d;
  logic [WIDTH-1:0]   e_op2_q,   e_op2_d;

  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q,    result_d;
  logic               eq_q,        eq_d;

  // Stage-R operands
  logic [WIDTH-1:0]   op1_rf, regop2_rf;
  logic [WIDTH-1:0]   op1, regop2, op2;

  // Stage-E datapath and control
  logic [WIDTH-1:0]   alu_out;
  logic               e_eq;
  logic               e_writes;
  logic               accept;
  logic               retire;
  logic               wr_en;

  // Stage E holds an instruction that will (unless flushed) write a real register
  assign e_writes = e_valid_q && e_we_q && (e_rd_q != '0);

  // Register-file read; x0 is forced to zero regardless of storage contents
  always_comb begin
    op1_rf    = '0;
    regop2_rf = '0;
    if (rs1 != '0) op1_rf    = regs_q[rs1];
    if (rs2 != '0) regop2_rf = regs_q[rs2];
  end

`ifdef FORWARD_EN
  logic fwd_ok;
  // A flushed stage-E instruction is dead and must not leak its value
  assign fwd_ok = e_writes && !flush;

  // Operand select with bypass of the live stage-E ALU output
  always_comb begin
    op1    = op1_rf;
    regop2 = regop2_rf;
    if (fwd_ok && (rs1 == e_rd_q)) op1    = alu_out;
    if (fwd_ok && (rs2 == e_rd_q)) regop2 = alu_out;
  end

  assign in_ready = !stall;
`else
  logic hazard;

  // Operands come straight from the register file
  always_comb begin
    op1    = op1_rf;
    regop2 = regop2_rf;
  end

  // Dependent issue waits one cycle for stage E to write back
  assign hazard   = in_valid && e_writes &&
                    ((rs1 == e_rd_q) || ((rs2 == e_rd_q) && !alu_src));
  assign in_ready = !stall && !hazard;
`endif

  assign op2    = alu_src ? imm : regop2;
  assign accept = in_valid && in_ready;

  // Stage-E ALU; shifts use only the low log2(WIDTH) bits of op2
  always_comb begin
    alu_out = '0;
    case (e_ctrl_q)
      OP_ADD:  alu_out = e_op1_q + e_op2_q;
      OP_SUB:  alu_out = e_op1_q - e_op2_q;
      OP_AND:  alu_out = e_op1_q & e_op2_q;
      OP_OR:   alu_out = e_op1_q | e_op2_q;
      OP_XOR:  alu_out = e_op1_q ^ e_op2_q;
      OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(e_op1_q) < $signed(e_op2_q))};
      OP_SLL:  alu_out = e_op1_q << e_op2_q[SHW-1:0];
      OP_SRL:  alu_out = e_op1_q >> e_op2_q[SHW-1:0];
      default: alu_out = '0;
    endcase
  end

  assign e_eq = (e_op1_q == e_op2_q);

  // flush kills the stage-E instruction ahead of its retire
  assign retire = e_valid_q && !stall && !flush;
  assign wr_en  = retire && e_we_q && (e_rd_q != '0);

  // Next-state for stage E and the registered outputs; everything holds on stall
  always_comb begin
    e_valid_d   = e_valid_q;
    e_rd_d      = e_rd_q;
    e_we_d      = e_we_q;
    e_ctrl_d    = e_ctrl_q;
    e_op1_d     = e_op1_q;
    e_op2_d     = e_op2_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    eq_d        = eq_q;
    if (!stall) begin
      e_valid_d = accept;
      if (accept) begin
        e_rd_d   = rd;
        e_we_d   = reg_write;
        e_ctrl_d = alu_ctrl;
        e_op1_d  = op1;
        e_op2_d  = op2;
      end
      out_valid_d = retire;
      if (retire) begin
        result_d = alu_out;
        eq_d     = e_eq;
      end
    end
  end

  // Stage-E and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_valid_q   <= 1'b0;
      e_rd_q      <= '0;
      e_we_q      <= 1'b0;
      e_ctrl_q    <= '0;
      e_op1_q     <= '0;
      e_op2_q     <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      eq_q        <= 1'b0;
    end else begin
      e_valid_q   <= e_valid_d;
      e_rd_q      <= e_rd_d;
      e_we_q      <= e_we_d;
      e_ctrl_q    <= e_ctrl_d;
      e_op1_q     <= e_op1_d;
      e_op2_q     <= e_op2_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      eq_q        <= eq_d;
    end
  end

  // Register file write-back from stage E
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[e_rd_q] <= alu_out;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign eq        = eq_q;

  // a0 (x10) only exists when there are at least 16 registers
  generate
    if (ADDRESS >= 4) begin : g_a0
      assign a0 = regs_q[10];
    end else begin : g_no_a0
      assign a0 = '0;
    end
  endgenerate

endmodule

// File: tb/tb_reg_alu_pipe.sv
// Directed testbench for reg_alu_pipe (default parameters, WIDTH=32, ADDRESS=5).
module tb_reg_alu_pipe;

  localparam int W = 32;
  localparam int A = 5;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [A-1:0] rs1, rs2, rd;
  logic         reg_write;
  logic         alu_src;
  logic [2:0]   alu_ctrl;
  logic [W-1:0] imm;
  logic         stall;
  logic         flush;
  logic         out_valid;
  logic [W-1:0] result;
  logic         eq;
  logic [W-1:0] a0;

  int n_checks = 0;
  int n_errors = 0;

  reg_alu_pipe #(.WIDTH(W), .ADDRESS(A)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .reg_write (reg_write),
    .alu_src   (alu_src),
    .alu_ctrl  (alu_ctrl),
    .imm       (imm),
    .stall     (stall),
    .flush     (flush),
    .out_valid (out_valid),
    .result    (result),
    .eq        (eq),
    .a0        (a0)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [A-1:0] s1, input logic [A-1:0] s2,
                           input logic [A-1:0] d, input logic we, input logic src,
                           input logic [2:0] ctrl, input logic [W-1:0] im);
    rs1       = s1;
    rs2       = s2;
    rd        = d;
    reg_write = we;
    alu_src   = src;
    alu_ctrl  = ctrl;
    imm       = im;
    in_valid  = 1'b1;
  endtask

  // Wait (bounded) for in_ready, then take the transfer edge
  task automatic accept();
    int cnt;
    cnt = 0;
    #1;
    while (!in_ready && cnt < 8) begin
      step();
      cnt++;
    end
    if (!in_ready) check("accept_timeout", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic issue(input logic [A-1:0] s1, input logic [A-1:0] s2,
                       input logic [A-1:0] d, input logic we, input logic src,
                       input logic [2:0] ctrl, input logic [W-1:0] im);
    set_instr(s1, s2, d, we, src, ctrl, im);
    accept();
  endtask

  // Issue one ALU op, let it retire, and check result/eq/out_valid
  task automatic run_vec(input string tag, input logic [A-1:0] s1, input logic [A-1:0] s2,
                         input logic [A-1:0] d, input logic src, input logic [2:0] ctrl,
                         input logic [W-1:0] im, input logic [W-1:0] exp_res,
                         input logic exp_eq);
    issue(s1, s2, d, 1'b1, src, ctrl, im);
    step();
    check({tag, "_ov"},  {31'b0, out_valid}, 32'd1);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_eq"},  {31'b0, eq}, {31'b0, exp_eq});
  endtask

  logic exp_hz_ready;

  initial begin
`ifdef FORWARD_EN
    exp_hz_ready = 1'b1;
`else
    exp_hz_ready = 1'b0;
`endif
    rst = 1'b1; in_valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0;
    reg_write = 1'b0; alu_src = 1'b0; alu_ctrl = '0; imm = '0;
    stall = 1'b0; flush = 1'b0;
    #12 rst = 1'b0;
    step();

    // 1. Reset state, addi x1 = x0 + 5, read back x1
    check("rst_ov",    {31'b0, out_valid}, 32'd0);
    check("rst_res",   result, 32'd0);
    check("rst_eq",    {31'b0, eq}, 32'd0);
    check("rst_a0",    a0, 32'd0);
    check("rst_ready", {31'b0, in_ready}, 32'd1);
    issue(5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 3'b000, 32'd5);
    step();
    check("addi_ov",  {31'b0, out_valid}, 32'd1);
    check("addi_res", result, 32'd5);
    check("addi_eq",  {31'b0, eq}, 32'd0);
    issue(5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 3'b000, 32'd0);
    check("bubble_ov", {31'b0, out_valid}, 32'd0);
    step();
    check("rd_x1_res", result, 32'd5);

    // 2. Back-to-back dependency x1 = 7; x2 = x1 + x1
    issue(5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 3'b000, 32'd7);
    set_instr(5'd1, 5'd1, 5'd2, 1'b1, 1'b0, 3'b000, 32'd0);
    #1;
    check("hazard_ready", {31'b0, in_ready}, {31'b0, exp_hz_ready});
    accept();
    step();
    check("dep_ov",  {31'b0, out_valid}, 32'd1);
    check("dep_res", result, 32'd14);
    check("dep_eq",  {31'b0, eq}, 32'd1);

    // 3. Write to x0 is discarded; x3 = x0 + 1; x10 drives a0
    issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 3'b000, 32'hFFFF_FFFF);
    issue(5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 3'b000, 32'd1);
    check("x0wr_res", result, 32'hFFFF_FFFF);
    step();
    check("x3_res", result, 32'd1);
    check("x0wr_a0", a0, 32'd0);
    issue(5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 3'b000, 32'h2A);
    check("a0_pre", a0, 32'd0);
    step();
    check("a0_post", a0, 32'h2A);
    check("a0_res",  result, 32'h2A);

    // 4. Stall with x8 = 0x33 in stage E
    issue(5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 3'b000, 32'h33);
    stall = 1'b1;
    set_instr(5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 3'b000, 32'h44);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_ov",    {31'b0, out_valid}, 32'd0);
      check("stall_res",   result, 32'h2A);
      check("stall_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    stall = 1'b0;
    step();
    check("unstall_ov",  {31'b0, out_valid}, 32'd1);
    check("unstall_res", result, 32'h33);
    step();
    check("once_ov",  {31'b0, out_valid}, 32'd0);
    check("once_res", result, 32'h33);
    run_vec("rd_x8", 5'd8, 5'd0, 5'd11, 1'b1, 3'b000, 32'd0, 32'h33, 1'b0);
    run_vec("rd_x9", 5'd9, 5'd0, 5'd11, 1'b1, 3'b000, 32'd0, 32'd0,  1'b1);

    // 5. Flush x4 = 9; x12 = 0x55 accepted on the same edge
    issue(5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 3'b000, 32'd9);
    set_instr(5'd0, 5'd0, 5'd12, 1'b1, 1'b1, 3'b000, 32'h55);
    flush = 1'b1;
    accept();
    flush = 1'b0;
    check("flush_ov",  {31'b0, out_valid}, 32'd0);
    check("flush_res", result, 32'd0);
    step();
    check("post_flush_ov",  {31'b0, out_valid}, 32'd1);
    check("post_flush_res", result, 32'h55);
    run_vec("rd_x4", 5'd4, 5'd0, 5'd13, 1'b1, 3'b000, 32'd0, 32'd0, 1'b1);

    // 6. ALU operations on x5 = 0x80000000, x6 = 1
    issue(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 3'b000, 32'h8000_0000);
    issue(5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 3'b000, 32'd1);
    step();
    run_vec("slt56",   5'd5, 5'd6, 5'd14, 1'b0, 3'b101, 32'd0,         32'd1,           1'b0);
    run_vec("slt65",   5'd6, 5'd5, 5'd15, 1'b0, 3'b101, 32'd0,         32'd0,           1'b0);
    run_vec("srl31",   5'd5, 5'd0, 5'd16, 1'b1, 3'b111, 32'd31,        32'd1,           1'b0);
    run_vec("sub66",   5'd6, 5'd6, 5'd17, 1'b0, 3'b001, 32'd0,         32'd0,           1'b1);
    run_vec("and56",   5'd5, 5'd6, 5'd18, 1'b0, 3'b010, 32'd0,         32'd0,           1'b0);
    run_vec("or56",    5'd5, 5'd6, 5'd19, 1'b0, 3'b011, 32'd0,         32'h8000_0001,   1'b0);
    run_vec("xori5",   5'd5, 5'd0, 5'd20, 1'b1, 3'b100, 32'hFFFF_FFFF, 32'h7FFF_FFFF,   1'b0);
    run_vec("slli4",   5'd6, 5'd0, 5'd21, 1'b1, 3'b110, 32'd4,         32'h10,          1'b0);
    run_vec("sll_msk", 5'd6, 5'd0, 5'd22, 1'b1, 3'b110, 32'h21,        32'd2,           1'b0);
    run_vec("sub_wrap",5'd0, 5'd6, 5'd23, 1'b0, 3'b001, 32'd0,         32'hFFFF_FFFF,   1'b0);
    run_vec("add_wrap",5'd5, 5'd5, 5'd24, 1'b0, 3'b000, 32'd0,         32'd0,           1'b1);

    // Reset mid-stream with x9 = 0x77 in stage E
    issue(5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 3'b000, 32'h77);
    #1 rst = 1'b1;
    #1;
    check("mrst_ov",  {31'b0, out_valid}, 32'd0);
    check("mrst_res", result, 32'd0);
    check("mrst_eq",  {31'b0, eq}, 32'd0);
    check("mrst_a0",  a0, 32'd0);
    #2 rst = 1'b0;
    step();
    check("mrst_drop_ov", {31'b0, out_valid}, 32'd0);
    run_vec("mrst_x9", 5'd9, 5'd0, 5'd25, 1'b1, 3'b000, 32'd3, 32'd3, 1'b0);
    run_vec("mrst_x5", 5'd5, 5'd0, 5'd26, 1'b1, 3'b000, 32'd0, 32'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
